// File: rtl/ps2_temp_entry_rx.sv
// PS/2 keyboard receiver that turns set-2 digit scan codes into a two-digit
// temperature setpoint (tens offset from 20 C plus units) for the display driver.
module ps2_temp_entry_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] uni,
    output logic [1:0] dec,
    output logic       temp_valid,
    output logic       entry_busy,
    output logic       rx_err
);

    // state   | meaning
    // F_IDLE  | waiting for a start bit
    // F_DATA  | shifting in 8 data bits, LSB first
    // F_PAR   | waiting for the parity bit
    // F_STOP  | waiting for the stop bit, then accept or flag error
    // E_IDLE  | no entry in progress
    // E_TENS  | tens digit held, waiting for units
    // E_UNITS | tens and units held, waiting for Enter
    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PAR, F_STOP} frame_state_e;
    typedef enum logic [1:0] {E_IDLE, E_TENS, E_UNITS} entry_state_e;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          ps2c_s;
    logic          data_s;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          strobe;

    frame_state_e  frm_q, frm_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    logic          byte_ok;
    logic          frame_err;
    logic [7:0]    byte_q;
    logic          byte_valid_q;
    logic          rx_err_q;

    logic          break_q;
    logic          key_evt;
    logic          is_digit, is_enter, is_bksp;
    logic [3:0]    digit_val;
    logic          dig_evt, enter_evt, bksp_evt;
    logic          tens_ok;

    entry_state_e  ent_q, ent_d;
    logic          load_tens, load_units, commit;
    logic [1:0]    pend_dec_q;
    logic [3:0]    pend_uni_q;
    logic [3:0]    uni_q;
    logic [1:0]    dec_q;
    logic          temp_valid_q;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign ps2c_s = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = FLT_LOAD;
        if (ps2c_s != filt_q) begin
            if (flt_cnt_q == '0) begin
                filt_d = ps2c_s;
            end else begin
                flt_cnt_d = flt_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= FLT_LOAD;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign strobe = filt_q & ~filt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_q <= F_IDLE;
        end else begin
            frm_q <= frm_d;
        end
    end

    always_comb begin
        frm_d = frm_q;
        case (frm_q)
            F_IDLE:  if (strobe && !data_s)            frm_d = F_DATA;
            F_DATA:  if (strobe && bit_cnt_q == 3'd7)  frm_d = F_PAR;
            F_PAR:   if (strobe)                       frm_d = F_STOP;
            F_STOP:  if (strobe)                       frm_d = F_IDLE;
            default:                                   frm_d = F_IDLE;
        endcase
        if (tmo_hit) begin
            frm_d = F_IDLE;
        end
    end

    always_comb begin
        tmo_hit   = (frm_q != F_IDLE) && !strobe && (tmo_q == '0);
        byte_ok   = (frm_q == F_STOP) && strobe && data_s && (^{shift_q, par_q});
        frame_err = ((frm_q == F_STOP) && strobe && !byte_ok) || tmo_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= TMO_LOAD;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            if (frm_q == F_IDLE) begin
                bit_cnt_q <= 3'd0;
            end else if (frm_q == F_DATA && strobe) begin
                shift_q   <= {data_s, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (frm_q == F_PAR && strobe) begin
                par_q <= data_s;
            end
            if (frm_q == F_IDLE || strobe) begin
                tmo_q <= TMO_LOAD;
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
            if (byte_ok) begin
                byte_q <= shift_q;
            end
            byte_valid_q <= byte_ok;
            rx_err_q     <= frame_err;
        end
    end

    // A break prefix swallows exactly one following byte, whatever it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_q <= 1'b0;
        end else if (byte_valid_q) begin
            if (break_q) begin
                break_q <= 1'b0;
            end else if (byte_q == 8'hF0) begin
                break_q <= 1'b1;
            end
        end
    end

    assign key_evt = byte_valid_q && !break_q && (byte_q != 8'hF0) && (byte_q != 8'hE0);

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (byte_q)
            8'h45:   digit_val = 4'd0;
            8'h16:   digit_val = 4'd1;
            8'h1E:   digit_val = 4'd2;
            8'h26:   digit_val = 4'd3;
            8'h25:   digit_val = 4'd4;
            8'h2E:   digit_val = 4'd5;
            8'h36:   digit_val = 4'd6;
            8'h3D:   digit_val = 4'd7;
            8'h3E:   digit_val = 4'd8;
            8'h46:   digit_val = 4'd9;
            default: is_digit  = 1'b0;
        endcase
        is_enter = (byte_q == 8'h5A);
        is_bksp  = (byte_q == 8'h66);
    end

    assign dig_evt   = key_evt & is_digit;
    assign enter_evt = key_evt & is_enter;
    assign bksp_evt  = key_evt & is_bksp;
    assign tens_ok   = (digit_val >= 4'd2) && (digit_val <= 4'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= E_IDLE;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_comb begin
        ent_d = ent_q;
        case (ent_q)
            E_IDLE:  if (dig_evt && tens_ok) ent_d = E_TENS;
            E_TENS: begin
                if (dig_evt)       ent_d = E_UNITS;
                else if (bksp_evt) ent_d = E_IDLE;
            end
            E_UNITS: begin
                if (enter_evt)     ent_d = E_IDLE;
                else if (bksp_evt) ent_d = E_TENS;
            end
            default:               ent_d = E_IDLE;
        endcase
    end

    always_comb begin
        entry_busy = (ent_q != E_IDLE);
        load_tens  = (ent_q == E_IDLE) && dig_evt && tens_ok;
        load_units = ((ent_q == E_TENS) || (ent_q == E_UNITS)) && dig_evt;
        commit     = (ent_q == E_UNITS) && enter_evt;
    end

    // Tens digits 2..5 map to offsets 0..3 by modulo-4 subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_dec_q   <= 2'd0;
            pend_uni_q   <= 4'd0;
            uni_q        <= 4'd0;
            dec_q        <= 2'd0;
            temp_valid_q <= 1'b0;
        end else begin
            if (load_tens) begin
                pend_dec_q <= digit_val[1:0] - 2'd2;
            end
            if (load_units) begin
                pend_uni_q <= digit_val;
            end
            if (commit) begin
                uni_q <= pend_uni_q;
                dec_q <= pend_dec_q;
            end
            temp_valid_q <= commit;
        end
    end

    assign uni        = {1'b0, uni_q};
    assign dec        = dec_q;
    assign temp_valid = temp_valid_q;
    assign rx_err     = rx_err_q;

endmodule
